// File: rtl/char_buffer_writer.sv
// ---------------------------------------------------------------------------
// char_buffer_writer
//
// Terminal-style writer for the circular ROWS x COLS character buffer that the
// on-screen text display reads. Printable bytes are written at the cursor.
// CR, LF and BS move the cursor. Writing past the last column wraps to the
// next line. A newline on the bottom row scrolls the screen: the new line is
// blanked, and first_char moves on by one row through the circular buffer.
//
// Optional build macro: CHAR_BUFFER_WRITER_FORMFEED_EN
//   When it is defined, byte 0x0C (form feed) clears the whole buffer and
//   homes the cursor. When it is undefined, 0x0C is ignored like any other
//   unknown byte.
//
// Ports:
//   clk                  system clock, rising edge
//   reset_n              synchronous active-low reset
//   in_data/in_valid     input byte stream
//   in_ready             byte accepted when in_valid && in_ready
//   char_buffer_address  write address into the character buffer
//   char_buffer_data     write data
//   char_buffer_we       one-cycle write strobe
//   cursor_x/cursor_y    cursor position on screen (row 0 = top)
//   cursor_blink_on      blink phase, toggles every BLINK_DIV cycles
//   first_char           buffer address of the top-left screen cell
//   busy                 high while a full clear or a scroll clear is running
// ---------------------------------------------------------------------------
module char_buffer_writer #(
  parameter int          ROWS       = 24,
  parameter int          COLS       = 80,
  parameter int          ROW_BITS   = 5,
  parameter int          COL_BITS   = 7,
  parameter int          ADDR_BITS  = 11,
  parameter logic [23:0] BLINK_DIV  = 24'd12_500_000,
  parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [ADDR_BITS-1:0] char_buffer_address,
  output logic [7:0]           char_buffer_data,
  output logic                 char_buffer_we,
  output logic [COL_BITS-1:0]  cursor_x,
  output logic [ROW_BITS-1:0]  cursor_y,
  output logic                 cursor_blink_on,
  output logic [ADDR_BITS-1:0] first_char,
  output logic                 busy
);

  localparam int TOTAL = ROWS * COLS;

  // The clear index carries one extra bit so that it can reach TOTAL itself.
  localparam logic [ADDR_BITS:0]   TOTAL_IDX = (ADDR_BITS+1)'(TOTAL);
  localparam logic [ADDR_BITS:0]   COLS_IDX  = (ADDR_BITS+1)'(COLS);
  localparam logic [ADDR_BITS:0]   ONE_IDX   = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS-1:0] COLS_A    = ADDR_BITS'(COLS);
  localparam logic [ADDR_BITS-1:0] LAST_LINE = ADDR_BITS'(TOTAL - COLS);
  localparam logic [COL_BITS-1:0]  LAST_COL  = COL_BITS'(COLS - 1);
  localparam logic [COL_BITS-1:0]  ONE_X     = COL_BITS'(1);
  localparam logic [ROW_BITS-1:0]  LAST_ROW  = ROW_BITS'(ROWS - 1);
  localparam logic [ROW_BITS-1:0]  ONE_Y     = ROW_BITS'(1);
  localparam logic [23:0]          BLINK_TOP = BLINK_DIV - 24'd1;

  localparam logic [1:0] S_CLEAR_ALL = 2'd0;
  localparam logic [1:0] S_IDLE      = 2'd1;
  localparam logic [1:0] S_WRITE     = 2'd2;
  localparam logic [1:0] S_SCROLL    = 2'd3;

  logic [1:0]           state_reg,      state_next;
  logic [ADDR_BITS:0]   idx_reg,        idx_next;
  logic [COL_BITS-1:0]  cursor_x_reg,   cursor_x_next;
  logic [ROW_BITS-1:0]  cursor_y_reg,   cursor_y_next;
  logic [ADDR_BITS-1:0] line_base_reg,  line_base_next;
  logic [ADDR_BITS-1:0] first_char_reg, first_char_next;
  logic [ADDR_BITS-1:0] addr_reg,       addr_next;
  logic [7:0]           data_reg,       data_next;
  logic                 we_reg,         we_next;
  logic                 in_ready_reg,   in_ready_next;
  logic                 busy_reg,       busy_next;
  logic [23:0]          blink_cnt_reg;
  logic                 blink_reg;

  logic                 newline;
  logic [ADDR_BITS-1:0] line_base_adv;
  logic [ADDR_BITS-1:0] first_char_adv;
  logic [ADDR_BITS-1:0] cursor_addr;

  // line_base and first_char are always whole-row multiples below TOTAL.
  // Advancing them only needs a compare against the last row, not a modulo.
  assign line_base_adv  = (line_base_reg  == LAST_LINE) ? '0 : line_base_reg  + COLS_A;
  assign first_char_adv = (first_char_reg == LAST_LINE) ? '0 : first_char_reg + COLS_A;
  assign cursor_addr    = line_base_reg + ADDR_BITS'(cursor_x_reg);

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    cursor_x_next   = cursor_x_reg;
    cursor_y_next   = cursor_y_reg;
    line_base_next  = line_base_reg;
    first_char_next = first_char_reg;
    addr_next       = addr_reg;
    data_next       = data_reg;
    we_next         = 1'b0;
    in_ready_next   = in_ready_reg;
    busy_next       = busy_reg;
    newline         = 1'b0;

    case (state_reg)
      S_CLEAR_ALL: begin
        if (idx_reg < TOTAL_IDX) begin
          we_next   = 1'b1;
          addr_next = idx_reg[ADDR_BITS-1:0];
          data_next = BLANK_CHAR;
          idx_next  = idx_reg + ONE_IDX;
        end else begin
          // Homing here is a no-op after reset.
          // It finishes a form-feed clear.
          state_next      = S_IDLE;
          in_ready_next   = 1'b1;
          busy_next       = 1'b0;
          cursor_x_next   = '0;
          cursor_y_next   = '0;
          line_base_next  = '0;
          first_char_next = '0;
        end
      end

      S_IDLE: begin
        if (in_ready_reg && in_valid) begin
          // Every accepted byte drops in_ready for at least one cycle.
          in_ready_next = 1'b0;
          if (in_data >= 8'h20 && in_data <= 8'h7E) begin
            state_next = S_WRITE;
            we_next    = 1'b1;
            addr_next  = cursor_addr;
            data_next  = in_data;
          end else begin
            case (in_data)
              8'h0D: cursor_x_next = '0;
              8'h0A: newline = 1'b1;
              8'h08: begin
                if (cursor_x_reg != '0) cursor_x_next = cursor_x_reg - ONE_X;
              end
`ifdef CHAR_BUFFER_WRITER_FORMFEED_EN
              8'h0C: begin
                state_next = S_CLEAR_ALL;
                idx_next   = '0;
                busy_next  = 1'b1;
              end
`endif
              default: ;
            endcase
          end
        end else begin
          in_ready_next = 1'b1;
        end
      end

      S_WRITE: begin
        state_next    = S_IDLE;
        in_ready_next = 1'b1;
        if (cursor_x_reg == LAST_COL) begin
          cursor_x_next = '0;
          newline       = 1'b1;
        end else begin
          cursor_x_next = cursor_x_reg + ONE_X;
        end
      end

      S_SCROLL: begin
        if (idx_reg < COLS_IDX) begin
          we_next   = 1'b1;
          addr_next = line_base_reg + idx_reg[ADDR_BITS-1:0];
          data_next = BLANK_CHAR;
          idx_next  = idx_reg + ONE_IDX;
        end else begin
          state_next      = S_IDLE;
          in_ready_next   = 1'b1;
          busy_next       = 1'b0;
          first_char_next = first_char_adv;
        end
      end

      default: state_next = S_CLEAR_ALL;
    endcase

    if (newline) begin
      line_base_next = line_base_adv;
      if (cursor_y_reg < LAST_ROW) begin
        cursor_y_next = cursor_y_reg + ONE_Y;
      end else begin
        // The bottom row scrolls. Blanking of the recycled row starts in the
        // next cycle at its column 0. The remaining columns follow in
        // S_SCROLL, so the scroll clear has no bubble cycle.
        state_next    = S_SCROLL;
        busy_next     = 1'b1;
        in_ready_next = 1'b0;
        we_next       = 1'b1;
        addr_next     = line_base_adv;
        data_next     = BLANK_CHAR;
        idx_next      = ONE_IDX;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= S_CLEAR_ALL;
      idx_reg        <= '0;
      cursor_x_reg   <= '0;
      cursor_y_reg   <= '0;
      line_base_reg  <= '0;
      first_char_reg <= '0;
      addr_reg       <= '0;
      data_reg       <= BLANK_CHAR;
      we_reg         <= 1'b0;
      in_ready_reg   <= 1'b0;
      busy_reg       <= 1'b1;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      cursor_x_reg   <= cursor_x_next;
      cursor_y_reg   <= cursor_y_next;
      line_base_reg  <= line_base_next;
      first_char_reg <= first_char_next;
      addr_reg       <= addr_next;
      data_reg       <= data_next;
      we_reg         <= we_next;
      in_ready_reg   <= in_ready_next;
      busy_reg       <= busy_next;
    end
  end

  // The blink timer runs in every state. Only reset touches it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blink_cnt_reg <= '0;
      blink_reg     <= 1'b0;
    end else if (blink_cnt_reg == BLINK_TOP) begin
      blink_cnt_reg <= '0;
      blink_reg     <= ~blink_reg;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + 24'd1;
    end
  end

  assign in_ready            = in_ready_reg;
  assign char_buffer_address = addr_reg;
  assign char_buffer_data    = data_reg;
  assign char_buffer_we      = we_reg;
  assign cursor_x            = cursor_x_reg;
  assign cursor_y            = cursor_y_reg;
  assign cursor_blink_on     = blink_reg;
  assign first_char          = first_char_reg;
  assign busy                = busy_reg;

endmodule
